// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        RESP
    } state_t;

    // Widest line the word selector accepts (64 words); narrower lines are zero-extended.
    localparam int MAX_LINE_W = 2048;

    // Index width that stays at least 1 bit, so single-entry dimensions remain legal.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line, input int idx);
        return line[32*idx +: 32];
    endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU age tracking per set: victim selection and age update on every access.
module icache_lru
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = width_of(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAYS-1:0]  valid_mask,
    output logic [WAY_W-1:0] victim,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way
);

    if (WAYS == 1) begin : g_single
        assign victim = '0;
        logic unused_lru;
        assign unused_lru = ^{clk, rst, idx, valid_mask, upd_we, upd_set, upd_way};
    end else begin : g_lru
        logic [WAY_W-1:0] age [SETS][WAYS];
        logic [WAY_W-1:0] max_age;
        logic             found;

        // An invalid way always wins; otherwise the oldest way is evicted.
        always_comb begin
            // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
            victim  = '0;
            found   = 1'b0;
            max_age = age[idx][0];
            for (int w = 0; w < WAYS; w++) begin
                if (!found && !valid_mask[w]) begin
                    victim = WAY_W'(w);
                    found  = 1'b1;
                end
            end
            if (!found) begin
                for (int w = 1; w < WAYS; w++) begin
                    if (age[idx][w] > max_age) begin
                        max_age = age[idx][w];
                        victim  = WAY_W'(w);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age[s][w] <= WAY_W'(w);
            end else if (upd_we) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == upd_way)
                        age[upd_set][w] <= '0;
                    else if (age[upd_set][w] < age[upd_set][upd_way])
                        age[upd_set][w] <= age[upd_set][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative blocking read-only instruction cache returning a fetch pair per request.
module icache_sa
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic                     addr_ready,
    input  logic                     inv,
    output logic                     data_ok,
    output logic                     hit,
    output logic [31:0]              rdata1,
    output logic [31:0]              rdata2,
    output logic                     rdata2_ok,
    output logic                     rd_req,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic                     ret_valid,
    input  logic [32*LINE_WORDS-1:0] ret_data
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int WAY_W  = width_of(WAYS);

    state_t state, state_next;

    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_off;

    logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
    logic [LINE_W-1:0] data_arr  [WAYS][SETS];
    logic [SETS-1:0]   valid_arr [WAYS];

    logic [WAYS-1:0]   set_valid, hit_vec;
    logic              hit_any, fill_we, lru_we;
    logic [WAY_W-1:0]  hit_way, victim, fill_way, sel_way, lru_way;
    logic [LINE_W-1:0] sel_line;

    logic              hit_q, rdata2_ok_q, rdata2_ok_now;
    logic [31:0]       rdata1_q, rdata2_q, rdata1_now, rdata2_now;

    logic unused_low;
    assign unused_low = ^req_addr[1:0];

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_off = req_addr[OFF_W-1:2];

    always_comb begin
        set_valid = '0;
        hit_vec   = '0;
        hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_arr[w][req_idx];
            hit_vec[w]   = valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag);
            if (hit_vec[w])
                hit_way = WAY_W'(w);
        end
    end
    assign hit_any = |hit_vec;

    icache_lru #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .idx        (req_idx),
        .valid_mask (set_valid),
        .victim     (victim),
        .upd_we     (lru_we),
        .upd_set    (req_idx),
        .upd_way    (lru_way)
    );

    always_comb begin
        state_next = state;
        addr_ready = 1'b0;
        data_ok    = 1'b0;
        rd_req     = 1'b0;
        lru_we     = 1'b0;
        lru_way    = hit_way;
        case (state)
            IDLE: begin
                addr_ready = !inv;
                if (valid && !inv)
                    state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit_any) begin
                    data_ok    = 1'b1;
                    lru_we     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = MISS;
                end
            end
            MISS: begin
                rd_req = 1'b1;
                if (ret_valid) begin
                    lru_we     = 1'b1;
                    lru_way    = victim;
                    state_next = RESP;
                end
            end
            RESP: begin
                data_ok    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fill_we = (state == MISS) && ret_valid;
    assign rd_addr = rd_req ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;

    // In RESP the line was just written into the victim way, which fill_way remembers.
    assign sel_way       = (state == RESP) ? fill_way : hit_way;
    assign sel_line      = data_arr[sel_way][req_idx];
    assign rdata2_ok_now = (req_off != WORD_W'(LINE_WORDS - 1));
    assign rdata1_now    = word_sel(MAX_LINE_W'(sel_line), int'(req_off));
    assign rdata2_now    = rdata2_ok_now ? word_sel(MAX_LINE_W'(sel_line), int'(req_off) + 1) : 32'h0;

    assign hit       = data_ok ? (state == LOOKUP) : hit_q;
    assign rdata1    = data_ok ? rdata1_now : rdata1_q;
    assign rdata2    = data_ok ? rdata2_now : rdata2_q;
    assign rdata2_ok = data_ok ? rdata2_ok_now : rdata2_ok_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            fill_way    <= '0;
            hit_q       <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            rdata2_ok_q <= 1'b0;
            for (int w = 0; w < WAYS; w++)
                valid_arr[w] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && valid && !inv)
                req_addr <= addr_i;
            if (state == IDLE && inv) begin
                for (int w = 0; w < WAYS; w++)
                    valid_arr[w] <= '0;
            end
            if (fill_we) begin
                valid_arr[victim][req_idx] <= 1'b1;
                fill_way                   <= victim;
            end
            if (data_ok) begin
                hit_q       <= hit;
                rdata1_q    <= rdata1;
                rdata2_q    <= rdata2;
                rdata2_ok_q <= rdata2_ok;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether they are meaningful.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[victim][req_idx]  <= req_tag;
            data_arr[victim][req_idx] <= ret_data;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: cold miss, hits, LRU eviction, invalidate, reset abort, stray inputs.
module tb_icache_sa;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [31:0]  addr_i = '0;
    logic         inv = 1'b0;
    logic         ret_valid = 1'b0;
    logic [127:0] ret_data = '0;
    logic         addr_ready, data_ok, hit, rdata2_ok, rd_req;
    logic [31:0]  rdata1, rdata2, rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE_T1 = 128'h34567891_02345678_91023456_78910234;
    localparam logic [127:0] LINE_A  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] LINE_B  = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [127:0] LINE_C  = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;

    always #5 clk = ~clk;

    icache_sa dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .addr_i     (addr_i),
        .addr_ready (addr_ready),
        .inv        (inv),
        .data_ok    (data_ok),
        .hit        (hit),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .rdata2_ok  (rdata2_ok),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present a request in IDLE; returns at the negedge of the LOOKUP cycle.
    task automatic request(input logic [31:0] a);
        @(negedge clk);
        valid  = 1'b1;
        addr_i = a;
        #1;
        check("accept_ready", addr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [31:0] w1, input logic [31:0] w2,
                              input logic ok2);
        request(a);
        check("hit_data_ok", data_ok, 1'b1);
        check("hit_flag", hit, 1'b1);
        check("hit_rdata1", rdata1, w1);
        check("hit_rdata2", rdata2, w2);
        check("hit_rdata2_ok", rdata2_ok, ok2);
        check("hit_no_rd_req", rd_req, 1'b0);
    endtask

    task automatic expect_miss(input logic [31:0] a, input logic [127:0] line, input int delay,
                               input logic busy_poke, input logic [31:0] w1, input logic [31:0] w2,
                               input logic ok2);
        request(a);
        check("lookup_no_data_ok", data_ok, 1'b0);
        @(negedge clk);
        check("miss_rd_req", rd_req, 1'b1);
        check("miss_rd_addr", rd_addr, a & 32'hFFFF_FFF0);
        if (busy_poke) begin
            valid  = 1'b1;
            addr_i = 32'h0000_0000;
            #1;
            check("busy_addr_ready", addr_ready, 1'b0);
        end
        for (int i = 1; i < delay; i++)
            @(negedge clk);
        valid = 1'b0;
        check("miss_rd_req_held", rd_req, 1'b1);
        check("miss_rd_addr_held", rd_addr, a & 32'hFFFF_FFF0);
        check("miss_no_data_ok", data_ok, 1'b0);
        ret_valid = 1'b1;
        ret_data  = line;
        @(negedge clk);
        ret_valid = 1'b0;
        ret_data  = '0;
        check("resp_data_ok", data_ok, 1'b1);
        check("resp_hit", hit, 1'b0);
        check("resp_rdata1", rdata1, w1);
        check("resp_rdata2", rdata2, w2);
        check("resp_rdata2_ok", rdata2_ok, ok2);
        check("resp_rd_req", rd_req, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr_ready", addr_ready, 1'b1);
        check("rst_data_ok", data_ok, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);
        check("rst_rdata2_ok", rdata2_ok, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_rd_addr", rd_addr, 32'h0);

        // Cold miss, then hold of the response after data_ok drops
        expect_miss(32'hDEBAD000, LINE_T1, 7, 1'b0, 32'h78910234, 32'h91023456, 1'b1);
        @(negedge clk);
        check("hold_data_ok", data_ok, 1'b0);
        check("hold_rdata1", rdata1, 32'h78910234);
        check("hold_rdata2", rdata2, 32'h91023456);
        check("hold_hit", hit, 1'b0);

        // Hits on the filled line
        expect_hit(32'hDEBAD008, 32'h02345678, 32'h34567891, 1'b1);
        expect_hit(32'hDEBAD00C, 32'h34567891, 32'h0, 1'b0);
        expect_hit(32'hDEBAD006, 32'h91023456, 32'h02345678, 1'b1);

        // LRU in set 0: C must evict B, not the recently hit A
        expect_miss(32'h0000_0000, LINE_A, 2, 1'b0, 32'hAAAA0000, 32'hAAAA0001, 1'b1);
        expect_miss(32'h0000_0400, LINE_B, 2, 1'b0, 32'hBBBB0000, 32'hBBBB0001, 1'b1);
        expect_hit(32'h0000_0004, 32'hAAAA0001, 32'hAAAA0002, 1'b1);
        expect_miss(32'h0000_0808, LINE_C, 2, 1'b0, 32'hCCCC0002, 32'hCCCC0003, 1'b1);
        expect_hit(32'h0000_000C, 32'hAAAA0003, 32'h0, 1'b0);
        expect_miss(32'h0000_0400, LINE_B, 3, 1'b0, 32'hBBBB0000, 32'hBBBB0001, 1'b1);

        // Invalidate beats a simultaneous request
        @(negedge clk);
        inv    = 1'b1;
        valid  = 1'b1;
        addr_i = 32'h0000_0000;
        #1;
        check("inv_addr_ready", addr_ready, 1'b0);
        @(negedge clk);
        inv   = 1'b0;
        valid = 1'b0;
        #1;
        check("inv_not_taken_ready", addr_ready, 1'b1);
        check("inv_no_data_ok", data_ok, 1'b0);
        check("inv_no_rd_req", rd_req, 1'b0);
        expect_miss(32'h0000_0000, LINE_A, 2, 1'b0, 32'hAAAA0000, 32'hAAAA0001, 1'b1);

        // Reset in the middle of a refill
        request(32'h0000_0400);
        @(negedge clk);
        check("abort_rd_req_before", rd_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rd_req", rd_req, 1'b0);
        check("abort_data_ok", data_ok, 1'b0);
        check("abort_addr_ready", addr_ready, 1'b1);
        ret_valid = 1'b1;
        ret_data  = LINE_B;
        @(negedge clk);
        ret_valid = 1'b0;
        ret_data  = '0;
        check("stray_after_rst_data_ok", data_ok, 1'b0);
        check("stray_after_rst_rd_req", rd_req, 1'b0);
        expect_miss(32'h0000_0400, LINE_B, 2, 1'b0, 32'hBBBB0000, 32'hBBBB0001, 1'b1);

        // Busy request during MISS, then a stray refill in IDLE
        expect_miss(32'h0000_0804, LINE_C, 4, 1'b1, 32'hCCCC0001, 32'hCCCC0002, 1'b1);
        @(negedge clk);
        ret_valid = 1'b1;
        ret_data  = LINE_T1;
        @(negedge clk);
        ret_valid = 1'b0;
        ret_data  = '0;
        check("stray_idle_data_ok", data_ok, 1'b0);
        check("stray_idle_rd_req", rd_req, 1'b0);
        check("stray_idle_addr_ready", addr_ready, 1'b1);
        expect_hit(32'h0000_0800, 32'hCCCC0000, 32'hCCCC0001, 1'b1);
        expect_hit(32'h0000_0408, 32'hBBBB0002, 32'hBBBB0003, 1'b1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
